// File: rtl/hs_ram_arbiter_if.sv
// Hiscore-side handshake bundle: a level request with stable address/data,
// answered by a one-cycle ack and held read data.
interface hs_ram_arbiter_if #(
    parameter int AW = 10,
    parameter int DW = 8
);
    logic          hs_req;
    logic          hs_we;
    logic [AW-1:0] hs_addr;
    logic [DW-1:0] hs_wdata;
    logic          hs_ack;
    logic [DW-1:0] hs_rdata;

    modport master (
        output hs_req, hs_we, hs_addr, hs_wdata,
        input  hs_ack, hs_rdata
    );

    modport slave (
        input  hs_req, hs_we, hs_addr, hs_wdata,
        output hs_ack, hs_rdata
    );
endinterface

// File: rtl/hs_ram_arbiter.sv
// Shares the single-port work RAM between the CPU (always first) and the hiscore
// engine, which is slotted into announced free cycles or forced in via pause_req.
module hs_ram_arbiter #(
    parameter int AW     = 10,
    parameter int DW     = 8,
    parameter int STARVE = 255
) (
    input  logic                 clk_sys,
    input  logic                 reset_n,
    input  logic                 cpu_free,
    input  logic                 paused,
    input  logic [AW-1:0]        cpu_addr,
    input  logic                 cpu_we,
    input  logic [DW-1:0]        cpu_wdata,
    hs_ram_arbiter_if.slave      hs,
    output logic [AW-1:0]        ram_addr,
    output logic                 ram_we,
    output logic [DW-1:0]        ram_wdata,
    input  logic [DW-1:0]        ram_rdata,
    output logic                 ram_sel,
    output logic                 pause_req
);

    typedef enum logic [1:0] {IDLE, ACCESS, CAPTURE, ACK} state_t;

    localparam logic [7:0] STARVE_LIM = 8'(STARVE);

    state_t        state_q, state_d;
    logic [7:0]    starve_cnt_q, starve_cnt_d;
    logic          pause_req_q, pause_req_d;
    logic [DW-1:0] hs_rdata_q, hs_rdata_d;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            starve_cnt_q <= '0;
            pause_req_q  <= 1'b0;
            hs_rdata_q   <= '0;
        end else begin
            state_q      <= state_d;
            starve_cnt_q <= starve_cnt_d;
            pause_req_q  <= pause_req_d;
            hs_rdata_q   <= hs_rdata_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        starve_cnt_d = starve_cnt_q;
        pause_req_d  = pause_req_q;
        hs_rdata_d   = hs_rdata_q;
        case (state_q)
            IDLE: begin
                if (!hs.hs_req) begin
                    starve_cnt_d = '0;
                    pause_req_d  = 1'b0;
                end else if (cpu_free || paused) begin
                    state_d = ACCESS;
                end else begin
                    if (starve_cnt_q != 8'hFF)
                        starve_cnt_d = starve_cnt_q + 8'd1;
                    if (starve_cnt_d >= STARVE_LIM)
                        pause_req_d = 1'b1;
                end
            end
            ACCESS:  state_d = hs.hs_we ? ACK : CAPTURE;
            CAPTURE: begin
                // RAM data for the ACCESS address is on ram_rdata this cycle.
                hs_rdata_d = ram_rdata;
                state_d    = ACK;
            end
            ACK:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // Clearing on entry keeps pause_req already low during the ack cycle.
        if (state_d == ACK) begin
            starve_cnt_d = '0;
            pause_req_d  = 1'b0;
        end
    end

    assign ram_sel     = (state_q == ACCESS);
    assign ram_addr    = ram_sel ? hs.hs_addr  : cpu_addr;
    assign ram_we      = ram_sel ? hs.hs_we    : cpu_we;
    assign ram_wdata   = ram_sel ? hs.hs_wdata : cpu_wdata;
    assign hs.hs_ack   = (state_q == ACK);
    assign hs.hs_rdata = hs_rdata_q;
    assign pause_req   = pause_req_q;

endmodule

// File: doc/hs_ram_arbiter.md
# hs_ram_arbiter

Shares the game's single-port work RAM between the Z80 CPU and the hiscore engine. The CPU always has priority. Hiscore reads and writes are slotted into cycles the CPU has announced as free. If the hiscore side waits too long, the block raises a pause request and completes the access once the CPU is paused. It sits between the hiscore module, the pause logic and the galaxian core's RAM port, all on clk_sys.

## Interface
Parameters:
- AW, 10: RAM address width.
- DW, 8: RAM data width.
- STARVE, 255: number of pending-but-ungranted cycles before pause_req asserts. Range 1..255.

Ports:
- clk_sys  in  1  system clock (12 MHz domain); the only clock.
- reset_n  in  1  asynchronous, active-low reset.
- cpu_free  in  1  CPU will not touch RAM in the next clk_sys cycle (lookahead from the CPU enable phase).
- paused  in  1  CPU is halted by the pause system; every cycle counts as free.
- cpu_addr / cpu_we / cpu_wdata  in  AW / 1 / DW  CPU RAM request.
- hs_req  in  1  hiscore request, level; address/data/we must stay stable until hs_ack.
- hs_we  in  1  1 = write, 0 = read.
- hs_addr / hs_wdata  in  AW / DW  hiscore address and write data.
- hs_ack  out  1  one-cycle completion pulse.
- hs_rdata  out  DW  read data; valid from the hs_ack cycle and held until the next read completes.
- ram_addr / ram_we / ram_wdata  out  AW / 1 / DW  muxed RAM port.
- ram_rdata  in  DW  synchronous RAM read data, one cycle after the address.
- ram_sel  out  1  1 = hiscore owns the RAM this cycle.
- pause_req  out  1  request to the pause system.

## Operation
- FSM states: IDLE, ACCESS, CAPTURE, ACK.
- IDLE:
  - If hs_req & (cpu_free | paused), go to ACCESS.
  - If hs_req & !(cpu_free | paused), increment starve_cnt (8-bit, saturating).
  - If !hs_req, clear starve_cnt.
- ACCESS:
  - ram_sel=1; ram_addr=hs_addr; ram_wdata=hs_wdata; ram_we=hs_we.
  - Next state: ACK if hs_we, CAPTURE if read.
- CAPTURE: ram_sel=0; hs_rdata <= ram_rdata at the end of the cycle. Next state ACK.
- ACK: hs_ack=1. Clear starve_cnt and pause_req. Next state IDLE.
- Outside ACCESS, the RAM port is combinationally driven from cpu_addr/cpu_we/cpu_wdata. The CPU path has zero added latency.
- pause_req:
  - Set on the cycle starve_cnt reaches STARVE while hs_req is high.
  - Cleared at ACK, or in IDLE when hs_req drops.
  - Never set in the same cycle it is cleared.
- The block never grants on paused alone unless hs_req is high. pause_req is its only means of forcing a slot.
- hs_req sampled high in IDLE on the cycle after ACK starts a new transaction, so back-to-back transfers are legal.

## Timing
- Reset values: hs_ack=0, hs_rdata=0, ram_sel=0, pause_req=0, starve_cnt=0, state=IDLE. ram_* follow cpu_* combinationally.
- Latency from a granting IDLE cycle t0:
  - Write: ACCESS at t0+1, hs_ack at t0+2.
  - Read: ACCESS at t0+1, CAPTURE at t0+2, hs_ack at t0+3.
- cpu_free sampled at t0 guarantees the CPU is idle at t0+1, the only cycle with ram_sel=1.
- Minimum spacing between back-to-back requests:
  - Writes: 3 cycles.
  - Reads: 4 cycles.
- Dropping hs_req during ACCESS, CAPTURE or ACK has no effect. The transaction completes and acks.
- Asynchronous reset mid-transaction:
  - The block immediately returns to IDLE with ram_sel=0.
  - An in-flight write is not guaranteed to have landed.
  - No hs_ack is issued for the aborted access.
- paused rising while starve_cnt is counting grants on that cycle. starve_cnt and pause_req are then cleared at ACK.

## Test plan
- Free write: cpu_free=1, hs_req=1, hs_we=1, hs_addr=0x155, hs_wdata=0xA5.
  - Expect ram_sel=1, ram_we=1, ram_addr=0x155 in exactly one cycle, then hs_ack 1 cycle later.
  - RAM[0x155]=0xA5; CPU port unchanged elsewhere.
- Free read: RAM[0x3FF]=0x5A, read 0x3FF.
  - Expect hs_ack 3 cycles after grant, hs_rdata=0x5A, held through the following idle cycles.
- Contention: cpu_free=0 for 10 cycles with hs_req high.
  - Expect ram_sel=0 throughout and CPU writes to 0x010 intact.
  - Grant occurs the cycle after cpu_free rises.
- Starvation with STARVE=4: cpu_free stuck at 0.
  - Expect pause_req after 4 waiting cycles.
  - Drive paused=1: expect grant, hs_ack, pause_req=0 on the ACK cycle.
- Reset mid-read: reset_n low during CAPTURE.
  - Expect all outputs at reset values, no hs_ack.
  - After release, a new read of 0x020 completes normally.
- Back-to-back: 16 writes then 16 reads with hs_req held high, cpu_free=1.
  - Expect acks every 3 cycles (writes) and every 4 cycles (reads), with all data matching.
